pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the ALU execute path.
- Splits a WIDTH-bit operation into STAGES equal carry-chained chunks, one chunk per pipeline stage.
- Accepts one operation per cycle under a valid/ready handshake with full backpressure.
- Returns the result plus carry, overflow, zero and sign flags, the inputs the condition-code logic needs.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and chunk count; 1 ≤ STAGES ≤ WIDTH; CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block accepts the operation this cycle.
- in_a  input  WIDTH  operand A, signed.
- in_b  input  WIDTH  operand B, signed.
- in_sub  input  1  0 computes A+B; 1 computes A−B.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  result.
- out_carry  output  1  raw carry out of MSB; for subtraction, 1 means no borrow.
- out_ovf  output  1  signed overflow.
- out_zf  output  1  out_sum == 0.
- out_sf  output  1  out_sum[WIDTH-1].

Behaviour:
- Reset (async assert, sync deassert is the integrator's concern):
  - All stage valid bits clear; out_valid=0.
  - out_sum=0, out_carry=0, out_ovf=0, out_zf=0, out_sf=0.
  - in_ready=1 once rst_n is high.
  - In-flight operations are discarded, with no partial output.
- Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
- Subtraction: B is bitwise inverted and carry-in is 1. Addition: carry-in is 0. in_sub is captured with the operands.
- Stage k (0..STAGES-1):
  - Adds chunk k of A and B' with the carry registered from stage k-1 (stage 0 uses the carry-in).
  - Registers the chunk sum and carry.
  - Carries forward the still-unused upper operand chunks (skew) and the completed lower sum chunks (de-skew).
- Latency: exactly STAGES cycles from an accepting edge to out_valid, when not stalled. Throughput is 1 op/cycle.
- Flow control: stage k advances when it is empty or stage k+1 advances. The last stage advances on out_ready or when empty. in_ready = stage 0 can advance.
  - in_ready is a combinational function of out_ready and the valid bits.
  - No combinational path from in_valid to out_valid or to in_ready.
- Stall: while out_valid=1 and out_ready=0, all output signals hold stable and no internal stage overwrites valid data. At most STAGES ops are buffered.
- Bubbles: an empty stage is collapsed by the upstream stage on the next edge, even while the output stalls.
- Simultaneous accept and deliver at full occupancy is legal; occupancy is unchanged.
- Flag rules:
  - out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - out_zf and out_sf are computed from the final full result, registered with it in the last stage.
- Wrap-around: results are modulo 2^WIDTH; nothing saturates.
- STAGES=1: a single registered full-width add with latency 1.
- Illegal parameters (WIDTH % STAGES ≠ 0) stop elaboration via a generate-time check.

Decomposition:
- Shared package alu_pkg:
  - Flag bundle typedef {carry, ovf, zf, sf}, reused by the CC register.
  - Constants ALU_WIDTH=64 and OP_ADD/OP_SUB encodings.
- One sub-module: adder_chunk, a combinational CHUNK-bit ripple adder built from full adder cells. Ports: a, b, cin, sum, cout, and c_msb_in (carry into its top bit, used by the final stage for overflow).
- The pipeline module instantiates STAGES adder_chunk instances through a generate loop.

Test Plan:
- WIDTH=64, STAGES=4, out_ready=1; add 3+5 → out_sum=8, carry=0, ovf=0, zf=0, sf=0, out_valid exactly 4 cycles after accept.
- Sub 5−7 → out_sum=0xFFFF_FFFF_FFFF_FFFE, carry=0 (borrow), sf=1. Sub 7−7 → sum=0, zf=1, carry=1.
- Add 0x7FFF_FFFF_FFFF_FFFF+1 → sum=0x8000_0000_0000_0000, ovf=1, sf=1. Add 0xFFFF_FFFF_FFFF_FFFF+1 → sum=0, carry=1, ovf=0, zf=1.
- Back-to-back stream of 100 random ops, out_ready=1 → one result per cycle, in order, all matching a reference model.
- Backpressure: out_ready=0 with in_valid held high → exactly 4 accepts, then in_ready=0 and outputs stable. Release → 4 results in order, no loss or duplication. Also random out_ready toggling.
- Reset (rst_n low for 1 cycle) with 3 ops in flight → out_valid=0 immediately and all outputs 0. After release, the next op's result arrives 4 cycles after accept. Repeat the sign/overflow cases with STAGES=1 and STAGES=8, WIDTH=32.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, opcode encodings, condition-flag bundle and full-adder cells
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Condition-code bundle, also the layout the CC register stores.
  typedef struct packed {
    logic carry;
    logic ovf;
    logic zf;
    logic sf;
  } alu_flags_t;

  localparam alu_flags_t ALU_FLAGS_RESET = '0;

  function automatic logic fa_sum(input logic a, input logic b, input logic cin);
    return a ^ b ^ cin;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic cin);
    return (a & b) | (cin & (a ^ b));
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational W-bit ripple adder built from full-adder cells
module adder_chunk
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  // The ripple is kept inside one block so the carry never forms a self-referencing vector.
  always_comb begin
    logic carry;
    carry    = cin;
    c_msb_in = cin;
    sum      = '0;
    for (int i = 0; i < W; i++) begin
      c_msb_in = carry;
      sum[i]   = fa_sum(a[i], b[i], carry);
      carry    = fa_carry(a[i], b[i], carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - STAGES-deep carry-chained add/subtract with valid/ready flow and CC flags
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zf,
  output logic             out_sf
);

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK       = WIDTH / SAFE_STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0]            stg_valid;
  logic [STAGES-1:0]            stg_vin;
  logic [STAGES-1:0]            stg_adv;
  logic [STAGES-1:0]            stg_carry;
  logic [STAGES-1:0]            cout_nx;
  logic [STAGES-1:0]            cmsb_nx;
  logic [STAGES-1:0][WIDTH-1:0] stg_a;
  logic [STAGES-1:0][WIDTH-1:0] stg_b;
  logic [STAGES-1:0][WIDTH-1:0] stg_sum;
  logic [STAGES-1:0][WIDTH-1:0] sum_nx;
  alu_flags_t                   flags_q;
  alu_flags_t                   flags_d;

  // A stage moves when it is empty or its successor moves, so bubbles collapse under a stall.
  always_comb begin
    stg_adv = '0;
    stg_adv[STAGES-1] = !stg_valid[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      stg_adv[k] = !stg_valid[k] || stg_adv[k+1];
    end
  end

  assign in_ready = stg_adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic             v_src;
    logic [CHUNK-1:0] chunk_sum;
    logic [WIDTH-1:0] s_nx;

    logic             valid_q, valid_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    // Stage 0 conditions B and the carry-in; later stages take the skewed operands forward.
    if (k == 0) begin : g_head
      assign a_src = in_a;
      assign b_src = (in_sub == OP_SUB) ? ~in_b : in_b;
      assign s_src = '0;
      assign c_src = (in_sub == OP_SUB);
      assign v_src = in_valid;
    end else begin : g_body
      assign a_src = stg_a[k-1];
      assign b_src = stg_b[k-1];
      assign s_src = stg_sum[k-1];
      assign c_src = stg_carry[k-1];
      assign v_src = stg_valid[k-1];
    end

    adder_chunk #(
      .W(CHUNK)
    ) u_chunk (
      .a        (a_src[k*CHUNK +: CHUNK]),
      .b        (b_src[k*CHUNK +: CHUNK]),
      .cin      (c_src),
      .sum      (chunk_sum),
      .cout     (cout_nx[k]),
      .c_msb_in (cmsb_nx[k])
    );

    always_comb begin
      s_nx = s_src;
      s_nx[k*CHUNK +: CHUNK] = chunk_sum;
    end

    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      if (stg_adv[k]) begin
        valid_d = v_src;
        if (v_src) begin
          carry_d = cout_nx[k];
          a_d     = a_src;
          b_d     = b_src;
          sum_d   = s_nx;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        a_q     <= '0;
        b_q     <= '0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
      end
    end

    assign stg_valid[k] = valid_q;
    assign stg_vin[k]   = v_src;
    assign stg_carry[k] = carry_q;
    assign stg_a[k]     = a_q;
    assign stg_b[k]     = b_q;
    assign stg_sum[k]   = sum_q;
    assign sum_nx[k]    = s_nx;
  end

  // Flags come from the completed result and are registered alongside it in the last stage.
  always_comb begin
    flags_d = flags_q;
    if (stg_adv[STAGES-1] && stg_vin[STAGES-1]) begin
      flags_d.carry = cout_nx[STAGES-1];
      flags_d.ovf   = cmsb_nx[STAGES-1] ^ cout_nx[STAGES-1];
      flags_d.zf    = (sum_nx[STAGES-1] == '0);
      flags_d.sf    = sum_nx[STAGES-1][WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= ALU_FLAGS_RESET;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign out_valid = stg_valid[STAGES-1];
  assign out_sum   = stg_sum[STAGES-1];
  assign out_carry = flags_q.carry;
  assign out_ovf   = flags_q.ovf;
  assign out_zf    = flags_q.zf;
  assign out_sf    = flags_q.sf;

  // Final-stage operand copies and inner-chunk MSB carries have no consumer.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{stg_a[STAGES-1], stg_b[STAGES-1], stg_carry[STAGES-1], cmsb_nx};

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - scoreboard bench for pipelined_addsub against an arithmetic reference
module tb_pipelined_addsub;

  localparam int W = 64;
  localparam int S = 4;

  typedef struct packed {
    logic [63:0] sum;
    logic        c;
    logic        v;
    logic        z;
    logic        s;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, out_valid, out_carry, out_ovf, out_zf, out_sf;
  logic [W-1:0] out_sum;

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .out_ovf(out_ovf), .out_zf(out_zf), .out_sf(out_sf)
  );

  logic        s_valid = 1'b0;
  logic        s_sub = 1'b0;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic        rdy1, v1, c1, o1, z1, f1;
  logic        rdy8, v8, c8, o8, z8, f8;
  logic [31:0] sum1, sum8;

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(rdy1),
    .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .out_valid(v1),
    .out_ready(1'b1), .out_sum(sum1), .out_carry(c1),
    .out_ovf(o1), .out_zf(z1), .out_sf(f1)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(rdy8),
    .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .out_valid(v8),
    .out_ready(1'b1), .out_sum(sum8), .out_carry(c8),
    .out_ovf(o8), .out_zf(z8), .out_sf(f8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_count = 0;
  bit lat_mode = 1'b0;
  bit rand_bp = 1'b0;
  res_t cur_exp;
  res_t exp_q[$];
  int   acc_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain modular and signed-integer arithmetic on w-bit operands.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic sub);
    res_t r;
    logic [65:0] modw, ua, ub, u;
    logic signed [65:0] sa, sb, sr, lim;
    modw = 66'd1 << w;
    ua = {2'b00, a} & (modw - 66'd1);
    ub = {2'b00, b} & (modw - 66'd1);
    u = sub ? (ua - ub) : (ua + ub);
    r.sum = 64'(u & (modw - 66'd1));
    r.c = sub ? (ua >= ub) : (u >= modw);
    sa = ua[w-1] ? $signed(ua - modw) : $signed(ua);
    sb = ub[w-1] ? $signed(ub - modw) : $signed(ub);
    sr = sub ? (sa - sb) : (sa + sb);
    lim = $signed(modw >> 1);
    r.v = (sr >= lim) || (sr < -lim);
    r.z = (r.sum == 64'd0);
    r.s = r.sum[w-1];
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      acc_q.push_back(cyc);
      acc_count++;
    end
  end

  logic [67:0] held;
  bit was_stalled = 1'b0;
  always @(negedge clk) begin
    res_t e;
    int   a;
    if (!rst_n) begin
      was_stalled = 1'b0;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", out_sum);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("result", {out_sum, out_carry, out_ovf, out_zf, out_sf}, e);
        if (lat_mode) check("latency", cyc - a, S);
      end
      was_stalled = 1'b0;
    end else if (out_valid) begin
      if (was_stalled) check("stall_hold", {out_sum, out_carry, out_ovf, out_zf, out_sf}, held);
      held = {out_sum, out_carry, out_ovf, out_zf, out_sf};
      was_stalled = 1'b1;
    end else begin
      was_stalled = 1'b0;
    end
  end

  task automatic send_exp(input logic [63:0] a, input logic [63:0] b, input logic sub, input res_t e);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = sub;
    cur_exp = e;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
    send_exp(a, b, sub, model(64, a, b, sub));
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [35:0] e);
    bit got1, got8;
    got1 = 1'b0;
    got8 = 1'b0;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_sub = sub;
    check("s32_ready", {rdy1, rdy8}, 2'b11);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      if (v1 && !got1) begin
        got1 = 1'b1;
        check("s1_latency", t, 1);
        check("s1_result", {sum1, c1, o1, z1, f1}, e);
      end
      if (v8 && !got8) begin
        got8 = 1'b1;
        check("s8_latency", t, 8);
        check("s8_result", {sum8, c8, o8, z8, f8}, e);
      end
      @(posedge clk);
      #1;
    end
    check("s1_seen", got1, 1'b1);
    check("s8_seen", got8, 1'b1);
  endtask

  task automatic run32_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    res_t r;
    r = model(32, {32'd0, a}, {32'd0, b}, sub);
    run32(a, b, sub, {r.sum[31:0], r.c, r.v, r.z, r.s});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, out_sum, out_carry, out_ovf, out_zf, out_sf}, 69'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", in_ready, 1'b1);
    @(posedge clk);
    #1;

    lat_mode = 1'b1;
    send_exp(64'd3, 64'd5, 1'b0, res_t'({64'd8, 4'b0000}));
    send_exp(64'd5, 64'd7, 1'b1, res_t'({64'hFFFF_FFFF_FFFF_FFFE, 4'b0001}));
    send_exp(64'd7, 64'd7, 1'b1, res_t'({64'd0, 4'b1010}));
    send_exp(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, res_t'({64'h8000_0000_0000_0000, 4'b0101}));
    send_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, res_t'({64'd0, 4'b1010}));
    drain();

    c0 = cyc;
    for (int i = 0; i < 100; i++) send(rand64(), rand64(), 1'($urandom_range(0, 1)));
    check("stream_cycles", cyc - c0, 100);
    drain();

    lat_mode = 1'b0;
    out_ready = 1'b0;
    a0 = acc_count;
    for (int i = 0; i < 4; i++) send(rand64(), rand64(), 1'($urandom_range(0, 1)));
    in_valid = 1'b1;
    in_a = rand64();
    in_b = rand64();
    in_sub = 1'b1;
    cur_exp = model(64, in_a, in_b, in_sub);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("stall_accepts", acc_count - a0, 4);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    check("release_accepts", acc_count - a0, 5);

    rand_bp = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(rand64(), rand64(), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_bp = 1'b0;
      end
      begin
        while (rand_bp) begin
          @(posedge clk);
          #1;
          if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    lat_mode = 1'b1;
    for (int i = 0; i < 4; i++) send(rand64(), rand64(), 1'($urandom_range(0, 1)));
    @(posedge clk);
    #1;
    check("valid_before_reset", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_in_flight", {out_valid, out_sum, out_carry, out_ovf, out_zf, out_sf}, 69'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("ready_after_flush", in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("no_output_after_flush", out_valid, 1'b0);
    send_exp(64'd7, 64'd7, 1'b1, res_t'({64'd0, 4'b1010}));
    drain();

    run32(32'd5, 32'd7, 1'b1, {32'hFFFF_FFFE, 4'b0001});
    run32(32'd7, 32'd7, 1'b1, {32'd0, 4'b1010});
    run32(32'h7FFF_FFFF, 32'd1, 1'b0, {32'h8000_0000, 4'b0101});
    run32(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 4'b1010});
    for (int i = 0; i < 8; i++) run32_model($urandom, $urandom, 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
